// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the shared-ALU side and the response channel of alu_arbiter.
// rsp_err is present only when ALU_OPCHECK_EN is defined.
interface alu_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req1_valid;
   logic [2:0]       req0_op;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req0_ready;
   logic             req1_ready;

   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_r;
   logic             alu_zero;

   logic             rsp0_valid;
   logic             rsp1_valid;
   logic             rsp0_ready;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp_r;
   logic             rsp_zero;
`ifdef ALU_OPCHECK_EN
   logic             rsp_err;
`endif

   // Requesters plus the shared ALU, seen from outside the arbiter.
   modport master (
      output req0_valid, req1_valid, req0_op, req1_op,
      output req0_a, req0_b, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_op, alu_a, alu_b,
      output alu_r, alu_zero,
      input  rsp0_valid, rsp1_valid,
      output rsp0_ready, rsp1_ready,
      input  rsp_r, rsp_zero
`ifdef ALU_OPCHECK_EN
      , input rsp_err
`endif
   );

   modport slave (
      input  req0_valid, req1_valid, req0_op, req1_op,
      input  req0_a, req0_b, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_op, alu_a, alu_b,
      input  alu_r, alu_zero,
      output rsp0_valid, rsp1_valid,
      input  rsp0_ready, rsp1_ready,
      output rsp_r, rsp_zero
`ifdef ALU_OPCHECK_EN
      , output rsp_err
`endif
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_8b between two requesters (IDLE -> EXEC -> RESP).
// Optional ALU_OPCHECK_EN: illegal opcodes bypass EXEC and answer with rsp_err=1.
module alu_arbiter #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_grant;
   logic             rr_armed;
   logic             owner;
   logic [2:0]       lat_op;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic             accept;
   logic             grant;
   logic             release_rsp;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   // Until the first response completes there is no history, so requester 0 wins a tie.
   assign grant = (bus.req0_valid && bus.req1_valid) ? (rr_armed & ~last_grant)
                                                     : bus.req1_valid;

   always_comb begin
      sel_op = bus.req0_op;
      sel_a  = bus.req0_a;
      sel_b  = bus.req0_b;
      if (grant) begin
         sel_op = bus.req1_op;
         sel_a  = bus.req1_a;
         sel_b  = bus.req1_b;
      end
   end

`ifdef ALU_OPCHECK_EN
   logic sel_illegal;
   assign sel_illegal = (sel_op == 3'b100) || (sel_op == 3'b110) || (sel_op == 3'b111);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      release_rsp = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (bus.req0_valid || bus.req1_valid)) begin
               accept = 1'b1;
`ifdef ALU_OPCHECK_EN
               state_next = sel_illegal ? RESP : EXEC;
`else
               state_next = EXEC;
`endif
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            // Only the owner's rsp_ready can complete the response.
            release_rsp = owner ? bus.rsp1_ready : bus.rsp0_ready;
            if (release_rsp) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = accept & ~grant;
      bus.req1_ready = accept & grant;
      bus.rsp0_valid = (state == RESP) & ~owner;
      bus.rsp1_valid = (state == RESP) & owner;
      bus.alu_op     = 3'b000;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      if (state == EXEC) begin
         bus.alu_op = lat_op;
         bus.alu_a  = lat_a;
         bus.alu_b  = lat_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner        <= 1'b0;
         last_grant   <= 1'b0;
         rr_armed     <= 1'b0;
         lat_op       <= 3'b000;
         lat_a        <= '0;
         lat_b        <= '0;
         bus.rsp_r    <= '0;
         bus.rsp_zero <= 1'b0;
`ifdef ALU_OPCHECK_EN
         bus.rsp_err  <= 1'b0;
`endif
      end else begin
         if (accept) begin
            owner  <= grant;
            lat_op <= sel_op;
            lat_a  <= sel_a;
            lat_b  <= sel_b;
`ifdef ALU_OPCHECK_EN
            bus.rsp_err <= sel_illegal;
            if (sel_illegal) begin
               bus.rsp_r    <= '0;
               bus.rsp_zero <= 1'b0;
            end
`endif
         end
         if (state == EXEC) begin
            bus.rsp_r    <= bus.alu_r;
            bus.rsp_zero <= bus.alu_zero;
         end
         if (release_rsp) begin
            last_grant <= owner;
            rr_armed   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the shared alu_8b.
// Expected responses are queued at accept and popped when the owner consumes them.
module tb_alu_arbiter;
   localparam int WIDTH = 8;

   typedef struct {
      logic             owner;
      logic [WIDTH-1:0] r;
      logic             zero;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb[$];

   alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b101:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: return 8'hA5;
      endcase
   endfunction

   always_comb begin
      bus.alu_r    = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
      bus.alu_zero = (bus.alu_r == '0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int who, input logic valid, input logic [2:0] op,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (who == 0) begin
         bus.req0_valid = valid;
         bus.req0_op    = op;
         bus.req0_a     = a;
         bus.req0_b     = b;
      end else begin
         bus.req1_valid = valid;
         bus.req1_op    = op;
         bus.req1_a     = a;
         bus.req1_b     = b;
      end
   endtask

   task automatic setRspReady(input int who, input logic value);
      if (who == 0) bus.rsp0_ready = value;
      else          bus.rsp1_ready = value;
   endtask

   task automatic checkResp(input string tag, input bit pop);
      exp_t e;
      if (sb.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("[TB] FAIL %s: response observed, expected an entry in the scoreboard", tag);
      end else begin
         e = sb[0];
         checkOutput({tag, "_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid},
                     {30'd0, e.owner, ~e.owner});
         checkOutput({tag, "_r"}, 32'(bus.rsp_r), 32'(e.r));
         checkOutput({tag, "_zero"}, 32'(bus.rsp_zero), 32'(e.zero));
`ifdef ALU_OPCHECK_EN
         checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
`endif
         if (pop) void'(sb.pop_front());
      end
   endtask

   // Called in an IDLE cycle; returns in the IDLE cycle that follows the consumed response.
   task automatic doTxn(input int who, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er, input logic ez,
                        input logic ee, input bit keep, input int hold);
      exp_t e;
      int   other;
      other = 1 - who;
      applyStimulus(who, 1'b1, op, a, b);
      #1;
      checkOutput("accept_ready0", 32'(bus.req0_ready), 32'(who == 0));
      checkOutput("accept_ready1", 32'(bus.req1_ready), 32'(who == 1));
      e.owner = (who == 1);
      e.r     = er;
      e.zero  = ez;
      e.err   = ee;
      sb.push_back(e);
      step();
      if (!keep) applyStimulus(who, 1'b0, 3'b000, '0, '0);
      if (!ee) begin
         #1;
         checkOutput("exec_op", 32'(bus.alu_op), 32'(op));
         checkOutput("exec_a", 32'(bus.alu_a), 32'(a));
         checkOutput("exec_b", 32'(bus.alu_b), 32'(b));
         checkOutput("exec_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
         checkOutput("exec_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
         step();
      end
      for (int h = 0; h < hold; h++) begin
         applyStimulus(other, 1'b1, 3'b000, 8'd1, 8'd1);
         setRspReady(other, 1'b1);
         #1;
         checkResp("resp_hold", 1'b0);
         checkOutput("hold_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
         step();
      end
      setRspReady(other, 1'b0);
      setRspReady(who, 1'b1);
      #1;
      checkResp("resp", 1'b1);
      checkOutput("resp_alu_op", 32'(bus.alu_op), 32'd0);
      checkOutput("resp_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      step();
      setRspReady(who, 1'b0);
      #1;
      checkOutput("idle_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      checkOutput("idle_alu", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(0, 1'b1, 3'b000, 8'd1, 8'd1);
      applyStimulus(1, 1'b0, 3'b000, 8'd0, 8'd0);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      step();
      step();
      checkOutput("reset_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      checkOutput("reset_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      checkOutput("reset_rsp_r", 32'(bus.rsp_r), 32'd0);
      checkOutput("reset_rsp_zero", 32'(bus.rsp_zero), 32'd0);
      checkOutput("reset_alu", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
`ifdef ALU_OPCHECK_EN
      checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
`endif
      applyStimulus(0, 1'b0, 3'b000, 8'd0, 8'd0);
      rst = 1'b0;
      step();

      // Single ADD from requester 0.
      doTxn(0, 3'b000, 8'd5, 8'd3, 8'd8, 1'b0, 1'b0, 1'b0, 0);

      // Fresh reset so requester 0 wins the first tie, then both stay valid.
      rst = 1'b1;
      step();
      rst = 1'b0;
      applyStimulus(0, 1'b1, 3'b001, 8'd7, 8'd7);
      applyStimulus(1, 1'b1, 3'b001, 8'd7, 8'd7);
      for (int k = 0; k < 4; k++) begin
         doTxn(k % 2, 3'b001, 8'd7, 8'd7, 8'd0, 1'b1, 1'b0, 1'b1, 0);
      end
      applyStimulus(0, 1'b0, 3'b000, 8'd0, 8'd0);
      applyStimulus(1, 1'b0, 3'b000, 8'd0, 8'd0);

      // SLT held unconsumed for 5 cycles while requester 0 waits.
      doTxn(1, 3'b101, 8'd2, 8'd9, 8'd1, 1'b0, 1'b0, 1'b0, 5);
      doTxn(0, 3'b000, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 0);

      // Reset during EXEC abandons the transaction.
      applyStimulus(1, 1'b1, 3'b000, 8'd4, 8'd4);
      #1;
      checkOutput("abort_accept", 32'(bus.req1_ready), 32'd1);
      step();
      applyStimulus(1, 1'b0, 3'b000, 8'd0, 8'd0);
      checkOutput("abort_exec_a", 32'(bus.alu_a), 32'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("abort_rsp_r", 32'(bus.rsp_r), 32'd0);
      checkOutput("abort_alu", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
      checkOutput("abort_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         checkOutput("abort_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
         step();
      end

      doTxn(0, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0);
      doTxn(1, 3'b011, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0);
      doTxn(0, 3'b101, 8'd9, 8'd2, 8'd0, 1'b1, 1'b0, 1'b0, 0);
`ifdef ALU_OPCHECK_EN
      doTxn(1, 3'b110, 8'd3, 8'd4, 8'd0, 1'b0, 1'b1, 1'b0, 0);
      doTxn(0, 3'b111, 8'd4, 8'd4, 8'd0, 1'b0, 1'b1, 1'b0, 0);
      doTxn(1, 3'b001, 8'd9, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0, 0);
`else
      doTxn(1, 3'b110, 8'd3, 8'd4, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
`endif

      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width; SHALL match alu_8b BITS.
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-006 req0_op / req1_op  input  3 each  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands.
REQ-008 req0_ready / req1_ready  output  1 each  one-cycle accept pulse to requester N.
REQ-009 alu_op  output  3  opcode driven to the shared alu_8b.
REQ-010 alu_a, alu_b  output  WIDTH each  operands driven to the shared alu_8b.
REQ-011 alu_r  input  WIDTH  ALU result R.
REQ-012 alu_zero  input  1  ALU zero_flag.
REQ-013 rsp0_valid / rsp1_valid  output  1 each  result available for requester N.
REQ-014 rsp0_ready / rsp1_ready  input  1 each  requester N consumes the result.
REQ-015 rsp_r  output  WIDTH  registered result, shared by both requesters.
REQ-016 rsp_zero  output  1  registered zero flag.
REQ-017 rsp_err  output  1  illegal opcode flag; exists only with ALU_OPCHECK_EN.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-019 IDLE: with any reqN_valid high, the block SHALL grant one requester, pulse its reqN_ready for that cycle, latch op/a/b, record owner, and go to EXEC.
REQ-020 Arbitration SHALL be round-robin: last_grant 1-bit; when both requests are valid, the grant goes to the requester not granted last; a single valid request is always granted.
REQ-021 EXEC: alu_op/alu_a/alu_b SHALL carry the latched values; at the clock edge, alu_r and alu_zero SHALL be captured into rsp_r and rsp_zero; go to RESP.
REQ-022 RESP: rspN_valid SHALL be high for owner N only, held with a stable rsp_r/rsp_zero until rspN_ready is high at a clock edge; then go to IDLE and set last_grant to owner.
REQ-023 Latency SHALL be: accept edge at cycle 0, rsp valid from cycle 2; minimum issue interval 3 cycles.
REQ-024 Outside EXEC, alu_op SHALL be 000 and alu_a/alu_b SHALL be 0.
REQ-025 reqN_ready SHALL never be high outside IDLE, and never for both requesters in the same cycle.
REQ-026 The owner of an accepted request SHALL be tracked even if its reqN_valid drops after acceptance.
REQ-027 The rsp_ready of the non-owner SHALL be ignored.
REQ-028 A request arriving during EXEC/RESP SHALL wait, with ready low, until the next IDLE cycle.

Reset
REQ-029 At rst high on a clock edge the block SHALL enter IDLE and clear last_grant (requester 0 has priority first).
REQ-030 Reset SHALL clear: rsp_r=0, rsp_zero=0, rsp_err=0, all ready and valid outputs=0, latched operands=0.
REQ-031 Reset mid-operation SHALL abandon the transaction; no response is produced afterwards.

Configuration
REQ-032 Macro ALU_OPCHECK_EN defined: opcodes 100, 110, 111 SHALL be accepted normally, skip EXEC (IDLE->RESP), and respond with rsp_err=1, rsp_r=0, rsp_zero=0; legal ops give rsp_err=0.
REQ-033 Macro ALU_OPCHECK_EN undefined: rsp_err port SHALL be absent; all opcodes SHALL go through EXEC, with the ALU output captured as-is.

Verification
REQ-034 Scenario: after reset, req0 ADD a=5 b=3 -> req0_ready at cycle 0, rsp0_valid at cycle 2, rsp_r=8, rsp_zero=0.
REQ-035 Scenario: req0 and req1 both valid continuously, both with SUB a=7 b=7 -> grants alternate 0,1,0,1; each rsp_r=0, rsp_zero=1.
REQ-036 Scenario: req1 SLT a=2 b=9, rsp1_ready held low for 5 cycles -> rsp1_valid and rsp_r=1 stable; no new grant until consumed.
REQ-037 Scenario: rst asserted in EXEC -> next cycle IDLE, all outputs zero, no rsp_valid pulse follows.
REQ-038 Scenario (ALU_OPCHECK_EN): req0 op=111 -> rsp0_valid at cycle 1, rsp_err=1, rsp_r=0; alu_op remains 000 throughout.
